dispatch: RTL and testbench
===========================

DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-002 Ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush
- ex_stall  in  1  execute cannot accept this cycle
- q_valid  in  2  decode-queue head slots valid; slot0 is the older instruction
- q_pc, q_inst  in  2x32  per slot
- q_aluop  in  2x8
- q_alusel  in  2x3
- q_imm  in  2x32
- q_reg1_en, q_reg2_en  in  2  source-read enables
- q_reg1_addr, q_reg2_addr  in  2x5
- q_reg_we  in  2
- q_reg_waddr  in  2x5
- q_is_privilege  in  2
- dequeue_en  out  2  per-slot dequeue acknowledge to the decode queue
- rf_raddr  out  4x5  regfile read addresses {s0r1, s0r2, s1r1, s1r2}
- rf_rdata  in  4x32  combinational regfile data
- ex_we, ex_is_load  in  2  execute-stage writes; load result not yet available
- ex_waddr  in  2x5
- ex_wdata  in  2x32
- mem_we  in  2
- mem_waddr  in  2x5
- mem_wdata  in  2x32
- issue_valid  out  2
- issue_pc, issue_inst, issue_imm, issue_src1, issue_src2  out  2x32
- issue_aluop  out  2x8
- issue_alusel  out  2x3
- issue_reg_we  out  2
- issue_reg_waddr  out  2x5

Function
REQ-003 All issue_* outputs SHALL be registered; an accepted slot appears on issue_* exactly 1 cycle after its dequeue_en pulse.
REQ-004 Issue SHALL be in order: slot1 issues only in a cycle where slot0 also issues; slot1 never issues alone.
REQ-005 dequeue_en[i] SHALL equal the slot-i issue decision in the same cycle, combinationally.
REQ-006 Slot0 SHALL issue iff q_valid[0], !ex_stall, !flush and no load-use hazard on slot0.
REQ-007 Load-use hazard: an enabled source with a nonzero address that equals ex_waddr[k] where ex_we[k] and ex_is_load[k] are set.
REQ-008 Slot1 SHALL additionally be blocked by any of:
- a load-use hazard on slot1;
- intra-pair RAW: q_reg_we[0], q_reg_waddr[0]!=0, and it matches an enabled slot1 source;
- q_is_privilege on either slot, so privileged instructions always issue alone in slot0;
- a WAW on the same nonzero destination.
REQ-009 Source operand priority SHALL be: address 0 yields 0, then ex slot1, ex slot0, mem slot1, mem slot0, then rf_rdata. Disabled sources SHALL yield 0.
REQ-010 When ex_stall=1, the issue registers SHALL hold their values and dequeue_en SHALL be 0.
REQ-011 When flush=1 (ex_stall ignored), dequeue_en SHALL be 0 and issue_valid SHALL clear next cycle.
REQ-012 When !ex_stall and no slot issues, issue_valid SHALL go to 0 next cycle (bubble).
REQ-013 For a slot not issued, issue_valid[i]=0; its issue_* data fields are don't-care.

Reset
REQ-014 While rst=1, the block SHALL:
- clear issue_valid, issue_reg_we and all issue data registers to 0 next cycle;
- hold dequeue_en at 0.
REQ-015 Reset SHALL take priority over flush and ex_stall.

Structure
REQ-016 ALU_SEL_* and ALU_OP_* encodings, the issue width (2) and the regfile port count (4) SHALL live in the shared core package.
REQ-017 Forwarding SHALL be one sub-module, dispatch_fwd, that resolves one source operand per REQ-009; it is instantiated 4 times.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Independent pair: add r1 and add r2, no hazards -> dequeue_en=2'b11, issue_valid=2'b11 next cycle.
- Intra-pair RAW: slot0 writes r5, slot1 reads r5 -> dequeue_en=2'b01; slot1 issues the following cycle with src1 forwarded from ex_wdata.
- Load-use: ex_is_load[0]=1 writing r3, slot0 reads r3 -> dequeue_en=2'b00 for 1 cycle, then issues with src from mem_wdata.
- Forward priority: ex slot1 and mem slot0 both write r7=0x11/0x22, slot0 reads r7 -> issue_src1=0x11; reading r0 -> 0.
- Stall then flush: ex_stall held 3 cycles -> outputs hold, dequeue_en=0; then flush=1 -> issue_valid=0 next cycle.
- Privileged in slot1: slot0 add, slot1 csrwr -> 2'b01; next cycle the csrwr issues alone.

Source files
------------

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared core encodings and widths for the dual-issue dispatch stage
package dispatch_pkg;
  localparam int ISSUE_W = 2;
  localparam int RF_PORTS = 4;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    ALU_SEL_NOP,
    ALU_SEL_LOGIC,
    ALU_SEL_SHIFT,
    ALU_SEL_ARITH,
    ALU_SEL_MUL,
    ALU_SEL_JUMP,
    ALU_SEL_LOAD_STORE,
    ALU_SEL_CSR
  } alu_sel_e;
  localparam logic [7:0] ALU_OP_NOP   = 8'h00;
  localparam logic [7:0] ALU_OP_AND   = 8'h01;
  localparam logic [7:0] ALU_OP_OR    = 8'h02;
  localparam logic [7:0] ALU_OP_XOR   = 8'h03;
  localparam logic [7:0] ALU_OP_NOR   = 8'h04;
  localparam logic [7:0] ALU_OP_SLL   = 8'h10;
  localparam logic [7:0] ALU_OP_SRL   = 8'h11;
  localparam logic [7:0] ALU_OP_SRA   = 8'h12;
  localparam logic [7:0] ALU_OP_ADD   = 8'h20;
  localparam logic [7:0] ALU_OP_SUB   = 8'h21;
  localparam logic [7:0] ALU_OP_SLT   = 8'h22;
  localparam logic [7:0] ALU_OP_SLTU  = 8'h23;
  localparam logic [7:0] ALU_OP_MUL   = 8'h30;
  localparam logic [7:0] ALU_OP_MULH  = 8'h31;
  localparam logic [7:0] ALU_OP_DIV   = 8'h32;
  localparam logic [7:0] ALU_OP_MOD   = 8'h33;
  localparam logic [7:0] ALU_OP_BEQ   = 8'h40;
  localparam logic [7:0] ALU_OP_BNE   = 8'h41;
  localparam logic [7:0] ALU_OP_JIRL  = 8'h42;
  localparam logic [7:0] ALU_OP_LDW   = 8'h50;
  localparam logic [7:0] ALU_OP_STW   = 8'h51;
  localparam logic [7:0] ALU_OP_CSRRD = 8'h60;
  localparam logic [7:0] ALU_OP_CSRWR = 8'h61;
  localparam logic [7:0] ALU_OP_ERTN  = 8'h62;
  function automatic logic wr_hit(input logic we, input logic [REG_AW-1:0] waddr, input logic [REG_AW-1:0] addr);
    return we && waddr == addr;
  endfunction
endpackage

// File: rtl/dispatch_fwd.sv
// dispatch_fwd: resolves one source operand through the bypass network and flags load-use
module dispatch_fwd
  import dispatch_pkg::*;
(
  input  logic                en,
  input  logic [REG_AW-1:0]   addr,
  input  logic [1:0]          ex_we,
  input  logic [1:0]          ex_is_load,
  input  logic [9:0]          ex_waddr,
  input  logic [63:0]         ex_wdata,
  input  logic [1:0]          mem_we,
  input  logic [9:0]          mem_waddr,
  input  logic [63:0]         mem_wdata,
  input  logic [DATA_W-1:0]   rf_data,
  output logic [DATA_W-1:0]   data,
  output logic                load_use
);
  logic [1:0] ex_hit;
  logic [1:0] mem_hit;
  // Youngest producer wins: ex slot1, ex slot0, mem slot1, mem slot0, then the regfile
  always_comb begin
    ex_hit = {wr_hit(ex_we[1], ex_waddr[9:5], addr), wr_hit(ex_we[0], ex_waddr[4:0], addr)};
    mem_hit = {wr_hit(mem_we[1], mem_waddr[9:5], addr), wr_hit(mem_we[0], mem_waddr[4:0], addr)};
    data = (!en || addr == '0) ? '0 :
           ex_hit[1]  ? ex_wdata[63:32] :
           ex_hit[0]  ? ex_wdata[31:0] :
           mem_hit[1] ? mem_wdata[63:32] :
           mem_hit[0] ? mem_wdata[31:0] : rf_data;
    load_use = en && addr != '0 && |(ex_hit & ex_is_load);
  end
endmodule

// File: rtl/dispatch.sv
// dispatch: in-order dual-issue dispatch with hazard checks and operand forwarding
module dispatch
  import dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic [1:0]  q_valid,
  input  logic [63:0] q_pc,
  input  logic [63:0] q_inst,
  input  logic [15:0] q_aluop,
  input  logic [5:0]  q_alusel,
  input  logic [63:0] q_imm,
  input  logic [1:0]  q_reg1_en,
  input  logic [1:0]  q_reg2_en,
  input  logic [9:0]  q_reg1_addr,
  input  logic [9:0]  q_reg2_addr,
  input  logic [1:0]  q_reg_we,
  input  logic [9:0]  q_reg_waddr,
  input  logic [1:0]  q_is_privilege,
  output logic [1:0]  dequeue_en,
  output logic [19:0] rf_raddr,
  input  logic [127:0] rf_rdata,
  input  logic [1:0]  ex_we,
  input  logic [1:0]  ex_is_load,
  input  logic [9:0]  ex_waddr,
  input  logic [63:0] ex_wdata,
  input  logic [1:0]  mem_we,
  input  logic [9:0]  mem_waddr,
  input  logic [63:0] mem_wdata,
  output logic [1:0]  issue_valid,
  output logic [63:0] issue_pc,
  output logic [63:0] issue_inst,
  output logic [63:0] issue_imm,
  output logic [63:0] issue_src1,
  output logic [63:0] issue_src2,
  output logic [15:0] issue_aluop,
  output logic [5:0]  issue_alusel,
  output logic [1:0]  issue_reg_we,
  output logic [9:0]  issue_reg_waddr
);
  logic [REG_AW-1:0] rd_addr [RF_PORTS];
  logic              rd_en [RF_PORTS];
  logic [DATA_W-1:0] src [RF_PORTS];
  logic [RF_PORTS-1:0] lu;
  logic raw;
  logic waw;
  logic [ISSUE_W-1:0] dq;
  // Port g serves slot g/2; even ports are source 1, odd ports source 2
  genvar g;
  for (g = 0; g < RF_PORTS; g++) begin : g_fwd
    assign rd_addr[g] = (g % 2) == 1 ? q_reg2_addr[5*(g/2) +: 5] : q_reg1_addr[5*(g/2) +: 5];
    assign rd_en[g] = (g % 2) == 1 ? q_reg2_en[g/2] : q_reg1_en[g/2];
    assign rf_raddr[5*g +: 5] = rd_addr[g];
    dispatch_fwd u_fwd (
      .en        (rd_en[g]),
      .addr      (rd_addr[g]),
      .ex_we     (ex_we),
      .ex_is_load(ex_is_load),
      .ex_waddr  (ex_waddr),
      .ex_wdata  (ex_wdata),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .rf_data   (rf_rdata[32*g +: 32]),
      .data      (src[g]),
      .load_use  (lu[g])
    );
  end
  // Issue decision: slot1 rides along only when slot0 goes and the pair is independent
  always_comb begin
    raw = q_reg_we[0] && q_reg_waddr[4:0] != '0 &&
          ((q_reg1_en[1] && q_reg1_addr[9:5] == q_reg_waddr[4:0]) ||
           (q_reg2_en[1] && q_reg2_addr[9:5] == q_reg_waddr[4:0]));
    waw = &q_reg_we && q_reg_waddr[4:0] != '0 && q_reg_waddr[4:0] == q_reg_waddr[9:5];
    dq[0] = !rst && q_valid[0] && !ex_stall && !flush && !(lu[0] || lu[1]);
    dq[1] = dq[0] && q_valid[1] && !(lu[2] || lu[3]) && !raw && !waw && !(|q_is_privilege);
    dequeue_en = dq;
  end
  // Issue registers: reset clears, flush kills, stall holds, otherwise capture the head pair
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid     <= '0;
      issue_pc        <= '0;
      issue_inst      <= '0;
      issue_imm       <= '0;
      issue_src1      <= '0;
      issue_src2      <= '0;
      issue_aluop     <= '0;
      issue_alusel    <= '0;
      issue_reg_we    <= '0;
      issue_reg_waddr <= '0;
    end else if (flush) begin
      issue_valid <= '0;
    end else if (!ex_stall) begin
      issue_valid     <= dq;
      issue_pc        <= q_pc;
      issue_inst      <= q_inst;
      issue_imm       <= q_imm;
      issue_src1      <= {src[2], src[0]};
      issue_src2      <= {src[3], src[1]};
      issue_aluop     <= q_aluop;
      issue_alusel    <= q_alusel;
      issue_reg_we    <= q_reg_we & dq;
      issue_reg_waddr <= q_reg_waddr;
    end
  end
endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: table-driven, directed and randomized checks of dispatch against a reference model
module tb_dispatch;
  import dispatch_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, ex_stall;
  logic [1:0] q_valid, q_reg1_en, q_reg2_en, q_reg_we, q_is_privilege;
  logic [1:0] dequeue_en, issue_valid, issue_reg_we, ex_we, ex_is_load, mem_we;
  logic [1:0][31:0] q_pc, q_inst, q_imm, ex_wdata, mem_wdata;
  logic [1:0][31:0] issue_pc, issue_inst, issue_imm, issue_src1, issue_src2;
  logic [1:0][7:0] q_aluop, issue_aluop;
  logic [1:0][2:0] q_alusel, issue_alusel;
  logic [1:0][4:0] q_reg1_addr, q_reg2_addr, q_reg_waddr, ex_waddr, mem_waddr, issue_reg_waddr;
  logic [3:0][4:0] rf_raddr;
  logic [3:0][31:0] rf_rdata;
  logic [31:0] rf_mem [32];
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] m_valid, m_we;
  logic [1:0][31:0] m_pc, m_inst, m_imm, m_src1, m_src2;
  logic [1:0][7:0] m_aluop;
  logic [1:0][2:0] m_alusel;
  logic [1:0][4:0] m_waddr;

  dispatch dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .q_valid(q_valid), .q_pc(q_pc), .q_inst(q_inst), .q_aluop(q_aluop),
    .q_alusel(q_alusel), .q_imm(q_imm), .q_reg1_en(q_reg1_en), .q_reg2_en(q_reg2_en),
    .q_reg1_addr(q_reg1_addr), .q_reg2_addr(q_reg2_addr), .q_reg_we(q_reg_we),
    .q_reg_waddr(q_reg_waddr), .q_is_privilege(q_is_privilege), .dequeue_en(dequeue_en),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .issue_valid(issue_valid), .issue_pc(issue_pc),
    .issue_inst(issue_inst), .issue_imm(issue_imm), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_aluop(issue_aluop), .issue_alusel(issue_alusel),
    .issue_reg_we(issue_reg_we), .issue_reg_waddr(issue_reg_waddr)
  );

  always #5 clk = ~clk;

  // Bench-side register file answers for the addresses the bench itself is presenting
  assign rf_rdata = {rf_mem[q_reg2_addr[1]], rf_mem[q_reg1_addr[1]], rf_mem[q_reg2_addr[0]], rf_mem[q_reg1_addr[0]]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] sa(input int s, input int r);
    return r == 1 ? q_reg2_addr[s] : q_reg1_addr[s];
  endfunction

  function automatic logic se(input int s, input int r);
    return r == 1 ? q_reg2_en[s] : q_reg1_en[s];
  endfunction

  function automatic logic load_use(input int s);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++)
        if (se(s, r) && sa(s, r) != 0 && ex_we[k] && ex_is_load[k] && ex_waddr[k] == sa(s, r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] fwd(input int s, input int r);
    logic w_en [4];
    logic [4:0] w_addr [4];
    logic [31:0] w_data [4];
    w_en = '{ex_we[1], ex_we[0], mem_we[1], mem_we[0]};
    w_addr = '{ex_waddr[1], ex_waddr[0], mem_waddr[1], mem_waddr[0]};
    w_data = '{ex_wdata[1], ex_wdata[0], mem_wdata[1], mem_wdata[0]};
    if (!se(s, r) || sa(s, r) == 0) return 32'h0;
    for (int j = 0; j < 4; j++)
      if (w_en[j] && w_addr[j] == sa(s, r)) return w_data[j];
    return rf_mem[sa(s, r)];
  endfunction

  function automatic logic [1:0] exp_dq();
    logic go0, go1, pair_raw, pair_waw;
    go0 = !rst && q_valid[0] && !ex_stall && !flush && !load_use(0);
    pair_raw = 1'b0;
    for (int r = 0; r < 2; r++)
      if (q_reg_we[0] && q_reg_waddr[0] != 0 && se(1, r) && sa(1, r) == q_reg_waddr[0]) pair_raw = 1'b1;
    pair_waw = q_reg_we[0] && q_reg_we[1] && q_reg_waddr[0] != 0 && q_reg_waddr[0] == q_reg_waddr[1];
    go1 = go0 && q_valid[1] && !load_use(1) && !pair_raw && !pair_waw && q_is_privilege == 2'b00;
    return {go1, go0};
  endfunction

  task automatic check_issue(input logic full);
    chk("issue_valid", 32'(issue_valid), 32'(m_valid));
    for (int s = 0; s < 2; s++)
      if (full || m_valid[s]) begin
        chk($sformatf("issue_pc[%0d]", s), issue_pc[s], m_pc[s]);
        chk($sformatf("issue_inst[%0d]", s), issue_inst[s], m_inst[s]);
        chk($sformatf("issue_imm[%0d]", s), issue_imm[s], m_imm[s]);
        chk($sformatf("issue_src1[%0d]", s), issue_src1[s], m_src1[s]);
        chk($sformatf("issue_src2[%0d]", s), issue_src2[s], m_src2[s]);
        chk($sformatf("issue_aluop[%0d]", s), 32'(issue_aluop[s]), 32'(m_aluop[s]));
        chk($sformatf("issue_alusel[%0d]", s), 32'(issue_alusel[s]), 32'(m_alusel[s]));
        chk($sformatf("issue_reg_we[%0d]", s), 32'(issue_reg_we[s]), 32'(m_we[s]));
        chk($sformatf("issue_reg_waddr[%0d]", s), 32'(issue_reg_waddr[s]), 32'(m_waddr[s]));
      end
  endtask

  // One clock: check combinational outputs, advance the model, then check the registers
  task automatic step();
    logic [1:0] e;
    logic [3:0][4:0] ra;
    logic was_rst;
    #3;
    e = exp_dq();
    chk("dequeue_en", 32'(dequeue_en), 32'(e));
    for (int p = 0; p < 4; p++) ra[p] = sa(p / 2, p % 2);
    chk("rf_raddr", 32'(rf_raddr), 32'(ra));
    was_rst = rst;
    if (rst) begin
      m_valid = '0; m_we = '0; m_pc = '0; m_inst = '0; m_imm = '0;
      m_src1 = '0; m_src2 = '0; m_aluop = '0; m_alusel = '0; m_waddr = '0;
    end else if (flush) begin
      m_valid = '0;
    end else if (!ex_stall) begin
      m_valid = e;
      for (int s = 0; s < 2; s++) begin
        m_pc[s] = q_pc[s]; m_inst[s] = q_inst[s]; m_imm[s] = q_imm[s];
        m_aluop[s] = q_aluop[s]; m_alusel[s] = q_alusel[s];
        m_we[s] = q_reg_we[s]; m_waddr[s] = q_reg_waddr[s];
        m_src1[s] = fwd(s, 0); m_src2[s] = fwd(s, 1);
      end
    end
    @(posedge clk);
    #1;
    check_issue(was_rst);
  endtask

  task automatic idle();
    rst = 0; flush = 0; ex_stall = 0;
    q_valid = '0; q_reg1_en = '0; q_reg2_en = '0; q_reg_we = '0; q_is_privilege = '0;
    q_reg1_addr = '0; q_reg2_addr = '0; q_reg_waddr = '0;
    q_pc = {32'h1c00_0004, 32'h1c00_0000};
    q_inst = {$urandom(), $urandom()}; q_imm = {$urandom(), $urandom()};
    q_aluop = {ALU_OP_ADD, ALU_OP_ADD}; q_alusel = {ALU_SEL_ARITH, ALU_SEL_ARITH};
    ex_we = '0; ex_is_load = '0; ex_waddr = '0; ex_wdata = '0;
    mem_we = '0; mem_waddr = '0; mem_wdata = '0;
  endtask

  task automatic hand_dq(input string name, input logic [1:0] exp);
    #3;
    chk(name, 32'(dequeue_en), 32'(exp));
  endtask

  typedef struct {
    logic [1:0] qv;
    logic stall, fl;
    logic [1:0] r1en;
    logic [4:0] a0, a1;
    logic [1:0] we;
    logic [4:0] w0, w1;
    logic [1:0] priv;
    logic exl;
    logic [4:0] exw;
    logic [1:0] dq;
  } vec_t;

  vec_t vt [16];

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
    vt[0]  = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 0, 5'd0, 2'b11};
    vt[1]  = '{2'b01, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 0, 5'd0, 2'b01};
    vt[2]  = '{2'b10, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 0, 5'd0, 2'b00};
    vt[3]  = '{2'b11, 1, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 0, 5'd0, 2'b00};
    vt[4]  = '{2'b11, 0, 1, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 0, 5'd0, 2'b00};
    vt[5]  = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd5, 2'b01, 5'd5, 5'd4, 2'b00, 0, 5'd0, 2'b01};
    vt[6]  = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd0, 2'b11, 5'd0, 5'd4, 2'b00, 0, 5'd0, 2'b11};
    vt[7]  = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd6, 5'd6, 2'b00, 0, 5'd0, 2'b01};
    vt[8]  = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd0, 5'd0, 2'b00, 0, 5'd0, 2'b11};
    vt[9]  = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b01, 0, 5'd0, 2'b01};
    vt[10] = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b10, 0, 5'd0, 2'b01};
    vt[11] = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 1, 5'd1, 2'b00};
    vt[12] = '{2'b11, 0, 0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 1, 5'd2, 2'b01};
    vt[13] = '{2'b11, 0, 0, 2'b00, 5'd1, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 1, 5'd1, 2'b11};
    vt[14] = '{2'b11, 0, 0, 2'b11, 5'd0, 5'd2, 2'b11, 5'd3, 5'd4, 2'b00, 1, 5'd0, 2'b11};
    vt[15] = '{2'b11, 0, 0, 2'b01, 5'd1, 5'd5, 2'b01, 5'd5, 5'd4, 2'b00, 0, 5'd0, 2'b11};

    idle();
    rst = 1; q_valid = 2'b11; ex_stall = 1; flush = 1;
    #1;
    step();
    step();
    chk("reset issue_valid", 32'(issue_valid), 32'h0);

    foreach (vt[i]) begin
      idle();
      q_valid = vt[i].qv; ex_stall = vt[i].stall; flush = vt[i].fl;
      q_reg1_en = vt[i].r1en; q_reg1_addr = {vt[i].a1, vt[i].a0};
      q_reg_we = vt[i].we; q_reg_waddr = {vt[i].w1, vt[i].w0};
      q_is_privilege = vt[i].priv;
      ex_we[0] = vt[i].exl; ex_is_load[0] = vt[i].exl; ex_waddr[0] = vt[i].exw;
      hand_dq($sformatf("vec%0d dequeue_en", i), vt[i].dq);
      step();
    end

    // Independent pair
    idle();
    q_valid = 2'b11; q_reg1_en = 2'b11; q_reg2_en = 2'b11;
    q_reg1_addr = {5'd3, 5'd1}; q_reg2_addr = {5'd4, 5'd2};
    q_reg_we = 2'b11; q_reg_waddr = {5'd2, 5'd1};
    hand_dq("pair dequeue_en", 2'b11);
    step();
    chk("pair issue_valid", 32'(issue_valid), 32'h3);
    chk("pair src1[1]", issue_src1[1], rf_mem[3]);

    // Intra-pair RAW, then slot1 issues with ex forwarding
    idle();
    q_valid = 2'b11; q_reg1_en = 2'b11; q_reg1_addr = {5'd5, 5'd1};
    q_reg_we = 2'b01; q_reg_waddr = {5'd0, 5'd5};
    hand_dq("raw dequeue_en", 2'b01);
    step();
    idle();
    q_valid = 2'b01; q_reg1_en = 2'b01; q_reg1_addr = {5'd0, 5'd5};
    ex_we = 2'b01; ex_waddr = {5'd0, 5'd5}; ex_wdata = {32'h0, 32'h55AA_0055};
    hand_dq("raw follow dequeue_en", 2'b01);
    step();
    chk("raw follow src1", issue_src1[0], 32'h55AA_0055);

    // Load-use bubble, then mem forwarding
    idle();
    q_valid = 2'b01; q_reg1_en = 2'b01; q_reg1_addr = {5'd0, 5'd3};
    ex_we = 2'b01; ex_is_load = 2'b01; ex_waddr = {5'd0, 5'd3}; ex_wdata = 32'hBAD0_BAD0;
    hand_dq("load-use dequeue_en", 2'b00);
    step();
    chk("load-use bubble", 32'(issue_valid), 32'h0);
    ex_we = '0; ex_is_load = '0;
    mem_we = 2'b01; mem_waddr = {5'd0, 5'd3}; mem_wdata = {32'h0, 32'h3333_3333};
    hand_dq("load-use retry dequeue_en", 2'b01);
    step();
    chk("load-use mem src1", issue_src1[0], 32'h3333_3333);

    // Forwarding priority and r0
    idle();
    q_valid = 2'b01; q_reg1_en = 2'b01; q_reg2_en = 2'b01;
    q_reg1_addr = {5'd0, 5'd7}; q_reg2_addr = {5'd0, 5'd0};
    ex_we = 2'b10; ex_waddr = {5'd7, 5'd0}; ex_wdata = {32'h11, 32'h0};
    mem_we = 2'b01; mem_waddr = {5'd0, 5'd7}; mem_wdata = {32'h0, 32'h22};
    step();
    chk("prio src1", issue_src1[0], 32'h11);
    chk("r0 src2", issue_src2[0], 32'h0);

    // Stall holds for 3 cycles, then flush kills
    idle();
    q_valid = 2'b01; q_pc = {32'h0, 32'h1c00_0100};
    step();
    q_pc = {32'h0, 32'h1c00_0200}; q_valid = 2'b11; ex_stall = 1;
    for (int c = 0; c < 3; c++) begin
      hand_dq("stall dequeue_en", 2'b00);
      step();
      chk("stall hold pc", issue_pc[0], 32'h1c00_0100);
      chk("stall hold valid", 32'(issue_valid), 32'h1);
    end
    flush = 1;
    hand_dq("flush dequeue_en", 2'b00);
    step();
    chk("flush issue_valid", 32'(issue_valid), 32'h0);

    // Privileged instruction in slot1 issues alone next cycle
    idle();
    q_valid = 2'b11; q_is_privilege = 2'b10;
    q_alusel = {ALU_SEL_CSR, ALU_SEL_ARITH}; q_aluop = {ALU_OP_CSRWR, ALU_OP_ADD};
    hand_dq("priv dequeue_en", 2'b01);
    step();
    idle();
    q_valid = 2'b01; q_is_privilege = 2'b01;
    q_alusel = {ALU_SEL_ARITH, ALU_SEL_CSR}; q_aluop = {ALU_OP_ADD, ALU_OP_CSRWR};
    hand_dq("priv alone dequeue_en", 2'b01);
    step();
    chk("priv alone alusel", 32'(issue_alusel[0]), 32'(ALU_SEL_CSR));

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rst = $urandom_range(0, 49) == 0;
      ex_stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 9) == 0;
      q_valid = 2'($urandom()); q_reg1_en = 2'($urandom()); q_reg2_en = 2'($urandom());
      q_reg_we = 2'($urandom());
      q_is_privilege = {$urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0};
      for (int s = 0; s < 2; s++) begin
        q_reg1_addr[s] = 5'($urandom_range(0, 7)); q_reg2_addr[s] = 5'($urandom_range(0, 7));
        q_reg_waddr[s] = 5'($urandom_range(0, 7));
        ex_waddr[s] = 5'($urandom_range(0, 7)); mem_waddr[s] = 5'($urandom_range(0, 7));
        q_pc[s] = $urandom(); q_inst[s] = $urandom(); q_imm[s] = $urandom();
        q_aluop[s] = 8'($urandom()); q_alusel[s] = 3'($urandom());
        ex_wdata[s] = $urandom(); mem_wdata[s] = $urandom();
      end
      ex_we = 2'($urandom()); ex_is_load = 2'($urandom()); mem_we = 2'($urandom());
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
